// File: rtl/iecdrv_sd_arb.sv
// Round-robin arbiter that shares the single host SD block channel among the IEC drives.
// One drive is granted at a time; ack, buffer strobes and buffer read data follow the grant.
module iecdrv_sd_arb #(
    parameter int DRIVES  = 3,
    parameter int TO_BITS = 24,
    localparam int NDR = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES),
    localparam int N   = NDR - 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [N:0]        drv_reset,
    input  logic [32*NDR-1:0] drv_lba,
    input  logic [6*NDR-1:0]  drv_blk_cnt,
    input  logic [N:0]        drv_rd,
    input  logic [N:0]        drv_wr,
    output logic [N:0]        drv_ack,
    output logic [N:0]        drv_buff_wr,
    input  logic [8*NDR-1:0]  drv_buff_din,
    output logic [31:0]       hps_lba,
    output logic [5:0]        hps_blk_cnt,
    output logic              hps_rd,
    output logic              hps_wr,
    input  logic              hps_ack,
    input  logic              hps_buff_wr,
    output logic [7:0]        hps_buff_din,
    output logic              busy
);
    localparam int GW = (NDR > 1) ? $clog2(NDR) : 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t             state, state_next;
    logic [GW-1:0]      grant, grant_next;
    logic [GW-1:0]      last, last_next;
    logic [GW-1:0]      pick, idx;
    logic               found;
    logic [TO_BITS-1:0] wd, wd_next;
    logic [31:0]        lba_next;
    logic [5:0]         cnt_next;
    logic               rd_next, wr_next;
    logic [N:0]         ack_reg, ack_next;
    logic [N:0]         req;

    assign req = (drv_rd | drv_wr) & ~drv_reset;

    // Rotating priority: the drive just after the last served one is looked at first.
    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NDR; k++) begin
            idx = GW'((int'(last) + k) % NDR);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        wd_next    = wd;
        lba_next   = hps_lba;
        cnt_next   = hps_blk_cnt;
        rd_next    = hps_rd;
        wr_next    = hps_wr;
        ack_next   = '0;
        unique case (state)
            IDLE: begin
                wd_next = '0;
                if (found) begin
                    grant_next = pick;
                    lba_next   = drv_lba[32*int'(pick) +: 32];
                    cnt_next   = drv_blk_cnt[6*int'(pick) +: 6];
                    rd_next    = drv_rd[pick];
                    wr_next    = drv_wr[pick] & ~drv_rd[pick];
                    state_next = REQ;
                end
            end
            REQ: begin
                // A host ack wins over a simultaneous withdraw: the host transfer has started.
                if (hps_ack) begin
                    rd_next         = 1'b0;
                    wr_next         = 1'b0;
                    ack_next[grant] = ~drv_reset[grant];
                    state_next      = XFER;
                end else if (!req[grant]) begin
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    state_next = IDLE;
                end else if (&wd) begin
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    last_next  = grant;
                    state_next = IDLE;
                end else begin
                    wd_next = wd + 1'b1;
                end
            end
            XFER: begin
                if (hps_ack) begin
                    ack_next[grant] = ~drv_reset[grant];
                end else begin
                    last_next  = grant;
                    wd_next    = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            last        <= GW'(N);
            wd          <= '0;
            hps_lba     <= '0;
            hps_blk_cnt <= '0;
            hps_rd      <= 1'b0;
            hps_wr      <= 1'b0;
            ack_reg     <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            last        <= last_next;
            wd          <= wd_next;
            hps_lba     <= lba_next;
            hps_blk_cnt <= cnt_next;
            hps_rd      <= rd_next;
            hps_wr      <= wr_next;
            ack_reg     <= ack_next;
        end
    end

    // A drive reset silences its ack and strobes at once, even mid-transfer.
    assign drv_ack = ack_reg & ~drv_reset;

    for (genvar gi = 0; gi < NDR; gi++) begin : g_strobe
        assign drv_buff_wr[gi] = (state == XFER) && hps_buff_wr &&
                                 (grant == GW'(gi)) && !drv_reset[gi];
    end

    assign hps_buff_din = drv_buff_din[8*int'(grant) +: 8];
    assign busy         = (state != IDLE);
endmodule
